// File: rtl/cu_fsm_mc.sv
// Multi-cycle RV32I control unit: sequences fetch/decode/execute/mem/writeback
// over a req/ack memory port and funnels illegal opcodes, timeouts and interrupts into one TRAP state.
module cu_fsm_mc #(
  parameter int MEM_TIMEOUT = 15,
  parameter bit INTR_EN     = 1'b1
) (
  input  logic       CLK,
  input  logic       RST_N,
  input  logic [6:0] opcode,
  input  logic       br_taken,
  input  logic       mem_ack,
  input  logic       intr,
  output logic       ir_write,
  output logic       pc_write,
  output logic       reg_write,
  output logic       mem_req,
  output logic       mem_we,
  output logic       mem_sel_data,
  output logic [2:0] imm_sel,
  output logic [1:0] pc_sel,
  output logic [1:0] rf_wr_sel,
  output logic [1:0] trap_cause,
  output logic [2:0] state_o
);

  typedef enum logic [2:0] {
    S_FETCH  = 3'd0,
    S_DECODE = 3'd1,
    S_EXEC   = 3'd2,
    S_MEM    = 3'd3,
    S_WB     = 3'd4,
    S_TRAP   = 3'd5
  } state_t;

  localparam logic [6:0] OP_LUI    = 7'b0110111;
  localparam logic [6:0] OP_AUIPC  = 7'b0010111;
  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_JALR   = 7'b1100111;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_IMM    = 7'b0010011;
  localparam logic [6:0] OP_OP     = 7'b0110011;

  localparam logic [7:0] CNT_LAST = 8'(MEM_TIMEOUT - 1);

  state_t     r_state;
  logic [7:0] r_cnt;
  logic [1:0] r_cause;

  state_t     w_nstate;
  logic [1:0] w_ncause;
  logic       w_legal, w_retire, w_cnt_last;
  logic       w_irw, w_pcw, w_rw, w_mreq, w_mwe, w_msel;
  logic [1:0] w_pcs, w_rfs;
  logic [2:0] w_imm;

  assign w_cnt_last = (r_cnt == CNT_LAST);

  always_comb begin
    w_legal = 1'b1;
    w_imm   = 3'd0;
    w_rfs   = 2'd0;
    case (opcode)
      OP_LUI:    begin w_imm = 3'd3; w_rfs = 2'd3; end
      OP_AUIPC:  begin w_imm = 3'd3; w_rfs = 2'd1; end
      OP_JAL:    begin w_imm = 3'd4; w_rfs = 2'd0; end
      OP_JALR:   begin w_imm = 3'd0; w_rfs = 2'd0; end
      OP_BRANCH: w_imm = 3'd2;
      OP_LOAD:   begin w_imm = 3'd0; w_rfs = 2'd2; end
      OP_STORE:  w_imm = 3'd1;
      OP_IMM:    begin w_imm = 3'd0; w_rfs = 2'd1; end
      OP_OP:     w_rfs = 2'd1;
      default:   w_legal = 1'b0;
    endcase
  end

  always_comb begin
    w_nstate = r_state;
    w_ncause = r_cause;
    w_retire = 1'b0;
    w_irw    = 1'b0;
    w_pcw    = 1'b0;
    w_rw     = 1'b0;
    w_mreq   = 1'b0;
    w_mwe    = 1'b0;
    w_msel   = 1'b0;
    w_pcs    = 2'd0;
    case (r_state)
      S_FETCH: begin
        w_mreq = 1'b1;
        if (mem_ack) begin
          w_irw    = 1'b1;
          w_nstate = S_DECODE;
        end else if (w_cnt_last) begin
          w_nstate = S_TRAP;
          w_ncause = 2'd2;
        end
      end
      S_DECODE: begin
        if (w_legal) begin
          w_nstate = S_EXEC;
        end else begin
          w_nstate = S_TRAP;
          w_ncause = 2'd1;
        end
      end
      S_EXEC: begin
        if (opcode == OP_LOAD || opcode == OP_STORE) begin
          w_nstate = S_MEM;
        end else begin
          w_pcw    = 1'b1;
          w_rw     = (opcode != OP_BRANCH);
          w_retire = 1'b1;
          if (opcode == OP_JAL)
            w_pcs = 2'd1;
          else if (opcode == OP_JALR)
            w_pcs = 2'd2;
          else if (opcode == OP_BRANCH && br_taken)
            w_pcs = 2'd1;
        end
      end
      S_MEM: begin
        w_mreq = 1'b1;
        w_msel = 1'b1;
        w_mwe  = (opcode == OP_STORE);
        // Ack beats the timeout when both land in the same cycle.
        if (mem_ack) begin
          if (opcode == OP_LOAD) begin
            w_nstate = S_WB;
          end else begin
            w_pcw    = 1'b1;
            w_retire = 1'b1;
          end
        end else if (w_cnt_last) begin
          w_nstate = S_TRAP;
          w_ncause = 2'd2;
        end
      end
      S_WB: begin
        w_rw     = 1'b1;
        w_pcw    = 1'b1;
        w_retire = 1'b1;
      end
      S_TRAP: begin
        w_pcw    = 1'b1;
        w_pcs    = 2'd3;
        w_nstate = S_FETCH;
      end
      default: w_nstate = S_FETCH;
    endcase
    if (w_retire) begin
      if (INTR_EN && intr) begin
        w_nstate = S_TRAP;
        w_ncause = 2'd3;
      end else begin
        w_nstate = S_FETCH;
      end
    end
  end

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      r_state <= S_FETCH;
      r_cnt   <= '0;
      r_cause <= 2'd0;
    end else begin
      r_state <= w_nstate;
      r_cause <= w_ncause;
      if (w_nstate != r_state)
        r_cnt <= '0;
      else if (w_mreq && !mem_ack)
        r_cnt <= r_cnt + 8'd1;
    end
  end

  // Strobes are gated by reset so an in-flight request drops asynchronously.
  assign ir_write     = w_irw  & RST_N;
  assign pc_write     = w_pcw  & RST_N;
  assign reg_write    = w_rw   & RST_N;
  assign mem_req      = w_mreq & RST_N;
  assign mem_we       = w_mwe  & RST_N;
  assign mem_sel_data = w_msel;
  assign imm_sel      = w_imm;
  assign pc_sel       = w_pcs;
  assign rf_wr_sel    = (r_state == S_WB) ? 2'd2 : w_rfs;
  assign trap_cause   = r_cause;
  assign state_o      = r_state;

endmodule
